// File: rtl/fp16_result_buffer_pkg.sv
// Shared FP16 field layout, status-flag bit positions and buffer entry type
// for the FP16 result buffer and its classifier.
package fp16_result_buffer_pkg;

  localparam int SIGN_BIT = 15;
  localparam int EXP_MSB  = 14;
  localparam int EXP_LSB  = 10;
  localparam int MAN_MSB  = 9;
  localparam int MAN_LSB  = 0;
  localparam logic [4:0] EXP_MAX = 5'd31;

  // Bit positions inside the 3-bit {exception, underflow, overflow} flag field
  localparam int FLAG_OVF = 0;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_EXC = 2;

  typedef enum logic [1:0] {
    CLS_ZERO   = 2'd0,
    CLS_NORMAL = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } fp16_class_e;

  typedef struct packed {
    logic [2:0]  flags;
    logic [15:0] value;
  } entry_t;

  function automatic logic [4:0] fp16_exp(input logic [15:0] v);
    return v[EXP_MSB:EXP_LSB];
  endfunction

  function automatic logic [9:0] fp16_man(input logic [15:0] v);
    return v[MAN_MSB:MAN_LSB];
  endfunction

endpackage

// File: rtl/fp16_classify.sv
// Combinational FP16 classifier: zero (exp=0, subnormals included), normal,
// infinity or NaN. The sign bit does not affect the class.
module fp16_classify
  import fp16_result_buffer_pkg::*;
(
  input  logic [15:0] value,
  output fp16_class_e cls
);

  logic [4:0] exp_f;
  logic [9:0] man_f;

  assign exp_f = fp16_exp(value);
  assign man_f = fp16_man(value);

  always_comb begin
    cls = CLS_NORMAL;
    if (exp_f == '0)
      cls = CLS_ZERO;
    else if (exp_f == EXP_MAX)
      cls = (man_f == '0) ? CLS_INF : CLS_NAN;
  end

endmodule

// File: rtl/fp16_result_buffer.sv
// First-word fall-through FIFO for FP16 multiplier results with sticky status
// flags and a saturating drop counter. Define FP16_RESBUF_CLASS_EN for o_class.
module fp16_result_buffer
  import fp16_result_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              i_res,
  input  logic                     i_res_vld,
  input  logic                     i_overflow,
  input  logic                     i_underflow,
  input  logic                     i_exception,
  output logic [15:0]              o_data,
  output logic [2:0]               o_flags,
  output logic                     o_vld,
  input  logic                     i_rdy,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [2:0]               o_sticky,
  input  logic                     i_clr_sticky,
  output logic [DROP_W-1:0]        o_drop_cnt
`ifdef FP16_RESBUF_CLASS_EN
  ,
  output logic [1:0]               o_class
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  entry_t           head;
  entry_t           in_entry;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic             drop;
  logic [2:0]       sticky_set;

  assign in_entry.flags = {i_exception, i_underflow, i_overflow};
  assign in_entry.value = i_res;

  assign o_full  = (o_count == CNT_W'(DEPTH));
  assign o_empty = (o_count == '0);
  assign o_vld   = !o_empty;

  assign pop  = o_vld && i_rdy;
  assign push = i_res_vld && (!o_full || pop);
  assign drop = i_res_vld && o_full && !pop;

  assign head    = mem[rd_ptr];
  assign o_data  = head.value;
  assign o_flags = head.flags;

`ifdef FP16_RESBUF_CLASS_EN
  fp16_class_e head_cls;
  fp16_class_e in_cls;

  fp16_classify u_head_classify (.value(head.value), .cls(head_cls));
  fp16_classify u_in_classify   (.value(i_res),      .cls(in_cls));

  assign o_class = head_cls;
`endif

  // Flags raised this cycle; they win over a simultaneous sticky clear
  always_comb begin
    sticky_set = '0;
    if (push)
      sticky_set = in_entry.flags;
    if (drop)
      sticky_set[FLAG_EXC] = 1'b1;
`ifdef FP16_RESBUF_CLASS_EN
    if (push && (in_cls == CLS_NAN))
      sticky_set[FLAG_EXC] = 1'b1;
`endif
  end

  // Storage is deliberately left out of reset; pointers alone define validity
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        o_count <= o_count + CNT_W'(1);
      else if (pop && !push)
        o_count <= o_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_sticky   <= '0;
      o_drop_cnt <= '0;
    end else if (i_clr_sticky) begin
      o_sticky   <= sticky_set;
      o_drop_cnt <= drop ? DROP_W'(1) : '0;
    end else begin
      o_sticky <= o_sticky | sticky_set;
      if (drop && (o_drop_cnt != '1))
        o_drop_cnt <= o_drop_cnt + DROP_W'(1);
    end
  end

endmodule
